// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg
// Shared definitions for the PS/2 scan-code sequencer:
//   - scan-code set 2 prefix bytes and the pause-sequence constants
//   - parser FSM state encoding
//   - bit positions inside a 10-bit key event {released, extended, code}
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_PAUSE   = 8'hE1;
  localparam logic [7:0] PAUSE_CODE = 8'h77;

  // Bytes that follow E1 in the pause sequence: 14 77 E1 F0 14 F0 77
  localparam int PAUSE_SKIP = 7;

  localparam int EVT_W   = 10;
  localparam int EVT_REL = 9;
  localparam int EVT_EXT = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } parse_state_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo
// First-word-fall-through event FIFO. The head entry is presented on o_data
// whenever the FIFO is not empty (zero when empty).
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push          write i_push_data (accepted when not full, or when a pop
//                   happens in the same cycle)
//   i_pop           remove head entry (ignored when empty)
//   o_data          head entry
//   o_empty/o_full  occupancy flags
//   o_count         occupancy, 0..DEPTH
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/ps2_scancode_sequencer.sv
// ps2_scancode_sequencer
// Pulls bytes from a PS/2 receiver, parses scan-code set 2 prefixes
// (E0 extended, F0 break, E1 pause) and queues key events for software.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_en             allow new byte requests (parser state held when low)
//   o_kbd_req        registered byte request to the receiver
//   i_kbd_data/err   byte and its parity-error flag, valid with i_kbd_ack
//   i_kbd_ack        one-cycle pulse: byte delivered (always consumed)
//   i_evt_rd         pop head event
//   o_evt_data       head event {released, extended, code}
//   o_evt_empty      event FIFO empty
//   o_evt_count      event FIFO occupancy
//   o_overflow       sticky: an event was dropped on a full FIFO
//   i_ovf_clr        clear o_overflow (a new drop in the same cycle wins)
//   o_err_count      saturating count of parity-errored bytes
module ps2_scancode_sequencer
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ERR_W = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic             o_kbd_req,
  input  logic [7:0]       i_kbd_data,
  input  logic             i_kbd_err,
  input  logic             i_kbd_ack,
  input  logic             i_evt_rd,
  output logic [EVT_W-1:0] o_evt_data,
  output logic             o_evt_empty,
  output logic [CNT_W-1:0] o_evt_count,
  output logic             o_overflow,
  input  logic             i_ovf_clr,
  output logic [ERR_W-1:0] o_err_count
);

  parse_state_t     r_state;
  parse_state_t     w_next_state;
  logic [2:0]       r_skip;
  logic [2:0]       w_next_skip;
  logic             w_push;
  logic [EVT_W-1:0] w_push_data;
  logic             w_byte_vld;
  logic             w_fifo_full;
  logic             w_drop;
  logic             r_req;
  logic             r_overflow;
  logic [ERR_W-1:0] r_err_count;

  assign w_byte_vld  = i_kbd_ack && !i_kbd_err;
  assign o_kbd_req   = r_req;
  assign o_overflow  = r_overflow;
  assign o_err_count = r_err_count;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
    end else begin
      r_state <= w_next_state;
      r_skip  <= w_next_skip;
    end
  end

  // Next-state logic. A parity error abandons any partial sequence.
  always_comb begin
    w_next_state = r_state;
    w_next_skip  = r_skip;
    if (i_kbd_ack) begin
      if (i_kbd_err) begin
        w_next_state = ST_IDLE;
        w_next_skip  = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_kbd_data == SC_EXT) begin
              w_next_state = ST_EXT;
            end else if (i_kbd_data == SC_BRK) begin
              w_next_state = ST_BRK;
            end else if (i_kbd_data == SC_PAUSE) begin
              w_next_state = ST_PAUSE;
              w_next_skip  = 3'(PAUSE_SKIP);
            end
          end
          ST_EXT: begin
            if (i_kbd_data == SC_BRK)      w_next_state = ST_EXT_BRK;
            else if (i_kbd_data != SC_EXT) w_next_state = ST_IDLE;
          end
          ST_PAUSE: begin
            w_next_skip = r_skip - 3'd1;
            if (r_skip == 3'd1) w_next_state = ST_IDLE;
          end
          default: w_next_state = ST_IDLE;
        endcase
      end
    end
  end

  // Event generation from the current state and the delivered byte.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    if (w_byte_vld) begin
      case (r_state)
        ST_IDLE: begin
          if (i_kbd_data != SC_EXT && i_kbd_data != SC_BRK &&
              i_kbd_data != SC_PAUSE) begin
            w_push      = 1'b1;
            w_push_data = {2'b00, i_kbd_data};
          end
        end
        ST_EXT: begin
          if (i_kbd_data != SC_EXT && i_kbd_data != SC_BRK) begin
            w_push               = 1'b1;
            w_push_data          = {2'b00, i_kbd_data};
            w_push_data[EVT_EXT] = 1'b1;
          end
        end
        ST_BRK: begin
          w_push               = 1'b1;
          w_push_data          = {2'b00, i_kbd_data};
          w_push_data[EVT_REL] = 1'b1;
        end
        ST_EXT_BRK: begin
          w_push               = 1'b1;
          w_push_data          = {2'b00, i_kbd_data};
          w_push_data[EVT_REL] = 1'b1;
          w_push_data[EVT_EXT] = 1'b1;
        end
        ST_PAUSE: begin
          if (r_skip == 3'd1) begin
            w_push               = 1'b1;
            w_push_data          = {2'b00, PAUSE_CODE};
            w_push_data[EVT_EXT] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A pop in the same cycle makes room, so only a push without pop is lost.
  assign w_drop = w_push && w_fifo_full && !i_evt_rd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req       <= 1'b0;
      r_overflow  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_req <= i_en && !w_fifo_full;
      if (w_drop)         r_overflow <= 1'b1;
      else if (i_ovf_clr) r_overflow <= 1'b0;
      if (i_kbd_ack && i_kbd_err && (r_err_count != '1))
        r_err_count <= r_err_count + 1'b1;
    end
  end

  ps2_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (i_evt_rd),
    .o_data      (o_evt_data),
    .o_empty     (o_evt_empty),
    .o_full      (w_fifo_full),
    .o_count     (o_evt_count)
  );

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// tb_ps2_scancode_sequencer
// Directed and randomized checks of the scan-code sequencer against a
// behavioural model: a byte-stream parser built from prefix flags plus a
// bounded event queue.
module tb_ps2_scancode_sequencer;

  localparam int DEPTH = 8;
  localparam int ERR_W = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             en = 1'b0;
  logic [7:0]       kbdData = 8'h00;
  logic             kbdErr = 1'b0;
  logic             kbdAck = 1'b0;
  logic             evtRd = 1'b0;
  logic             ovfClr = 1'b0;
  logic             kbdReq;
  logic [9:0]       evtData;
  logic             evtEmpty;
  logic [CNT_W-1:0] evtCount;
  logic             overflow;
  logic [ERR_W-1:0] errCount;

  always #5 clk = ~clk;

  ps2_scancode_sequencer #(
    .DEPTH (DEPTH),
    .ERR_W (ERR_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_en        (en),
    .o_kbd_req   (kbdReq),
    .i_kbd_data  (kbdData),
    .i_kbd_err   (kbdErr),
    .i_kbd_ack   (kbdAck),
    .i_evt_rd    (evtRd),
    .o_evt_data  (evtData),
    .o_evt_empty (evtEmpty),
    .o_evt_count (evtCount),
    .o_overflow  (overflow),
    .i_ovf_clr   (ovfClr),
    .o_err_count (errCount)
  );

  int nChecks = 0;
  int nFail   = 0;

  // Reference model state
  int mq[$];
  bit mExt;
  bit mBrk;
  int mPauseLeft;
  int mErr;
  bit mOvf;
  bit mReq;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] expHead;
    expHead = (mq.size() > 0) ? 32'(mq[0]) : 32'd0;
    checkVal({tag, ".empty"}, 32'(evtEmpty), 32'(mq.size() == 0));
    checkVal({tag, ".count"}, 32'(evtCount), 32'(mq.size()));
    checkVal({tag, ".data"},  32'(evtData),  expHead);
    checkVal({tag, ".ovf"},   32'(overflow), 32'(mOvf));
    checkVal({tag, ".err"},   32'(errCount), 32'(mErr));
    checkVal({tag, ".req"},   32'(kbdReq),   32'(mReq));
  endtask

  task automatic modelReset();
    mq.delete();
    mExt = 0;
    mBrk = 0;
    mPauseLeft = 0;
    mErr = 0;
    mOvf = 0;
    mReq = 0;
  endtask

  // Scan-code set 2 rules: E0 marks extended, F0 marks release, E1 starts a
  // pause sequence whose next seven bytes collapse into one extended 77.
  // Prefix bytes only count as prefixes where they can legally appear.
  task automatic modelByte(input logic [7:0] b, input logic e,
                           output bit hasEvt, output int evt);
    hasEvt = 0;
    evt = 0;
    if (e) begin
      mExt = 0;
      mBrk = 0;
      mPauseLeft = 0;
      if (mErr < ERR_MAX) mErr++;
    end else if (mPauseLeft > 0) begin
      mPauseLeft--;
      if (mPauseLeft == 0) begin
        hasEvt = 1;
        evt = 'h177;
      end
    end else if (b == 8'hE0 && !mBrk) begin
      mExt = 1;
    end else if (b == 8'hF0 && !mBrk) begin
      mBrk = 1;
    end else if (b == 8'hE1 && !mExt && !mBrk) begin
      mPauseLeft = 7;
    end else begin
      hasEvt = 1;
      evt = (int'(mBrk) << 9) | (int'(mExt) << 8) | int'(b);
      mExt = 0;
      mBrk = 0;
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check at
  // the following falling edge.
  task automatic applyStimulus(input logic ack, input logic [7:0] b, input logic e,
                               input logic rd, input logic clr, input string tag);
    bit hasEvt;
    bit dropped;
    bit reqNext;
    int evt;
    kbdAck = ack;
    kbdData = b;
    kbdErr = e;
    evtRd = rd;
    ovfClr = clr;
    @(posedge clk);
    reqNext = en && (mq.size() < DEPTH);
    dropped = 0;
    if (rd && mq.size() > 0) void'(mq.pop_front());
    if (ack) begin
      modelByte(b, e, hasEvt, evt);
      if (hasEvt) begin
        if (mq.size() < DEPTH) mq.push_back(evt);
        else dropped = 1;
      end
    end
    if (dropped) mOvf = 1;
    else if (clr) mOvf = 0;
    mReq = reqNext;
    @(negedge clk);
    checkOutput(tag);
    kbdAck = 0;
    kbdErr = 0;
    evtRd = 0;
    ovfClr = 0;
  endtask

  task automatic sendByte(input logic [7:0] b, input string tag);
    applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic popEvent(input string tag);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) popEvent(tag);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, tag);
    checkVal({tag, ".drained"}, 32'(evtEmpty), 32'd1);
  endtask

  task automatic applyReset(input string tag);
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    logic [7:0] pauseSeq [8];
    logic [7:0] rb;
    int r;
    pauseSeq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    @(negedge clk);
    applyReset("reset");
    en = 1'b1;
    idleCycle("req_up");
    checkVal("req_after_en", 32'(kbdReq), 32'd1);

    // Plain make then break
    sendByte(8'h1C, "make");
    checkVal("make.head", 32'(evtData), 32'h01C);
    checkVal("make.nonempty", 32'(evtEmpty), 32'd0);
    sendByte(8'hF0, "brk.pre");
    sendByte(8'h1C, "brk.code");
    popEvent("brk.pop");
    checkVal("brk.head", 32'(evtData), 32'h21C);
    drain("t1");

    // Extended make and break
    sendByte(8'hE0, "ext.pre");
    sendByte(8'h75, "ext.code");
    sendByte(8'hE0, "extbrk.pre1");
    sendByte(8'hF0, "extbrk.pre2");
    sendByte(8'h75, "extbrk.code");
    checkVal("ext.count", 32'(evtCount), 32'd2);
    checkVal("ext.head", 32'(evtData), 32'h175);
    popEvent("ext.pop");
    checkVal("extbrk.head", 32'(evtData), 32'h375);
    drain("t2");

    // Pause sequence collapses to one event
    for (int i = 0; i < 8; i++) sendByte(pauseSeq[i], "pause");
    checkVal("pause.count", 32'(evtCount), 32'd1);
    checkVal("pause.head", 32'(evtData), 32'h177);
    drain("t3");

    // Parity error on a break prefix resynchronises the parser
    applyStimulus(1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, "perr");
    sendByte(8'h1C, "perr.code");
    checkVal("perr.errcnt", 32'(errCount), 32'd1);
    checkVal("perr.count", 32'(evtCount), 32'd1);
    checkVal("perr.head", 32'(evtData), 32'h01C);
    drain("t4");

    // Fill, overflow, clear, drain in order
    for (int i = 0; i < DEPTH; i++) sendByte(8'(8'h10 + i), "fill");
    idleCycle("fill.idle");
    checkVal("fill.req_low", 32'(kbdReq), 32'd0);
    sendByte(8'h30, "ovf.forced");
    checkVal("ovf.set", 32'(overflow), 32'd1);
    checkVal("ovf.count", 32'(evtCount), 32'(DEPTH));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "ovf.clr");
    checkVal("ovf.cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      checkVal("fifo.order", 32'(evtData), 32'(10'h010 + i));
      popEvent("fifo.pop");
    end
    checkVal("fifo.empty", 32'(evtEmpty), 32'd1);
    popEvent("pop.empty");

    // Reset in the middle of E0 F0
    sendByte(8'hE0, "mid.pre1");
    sendByte(8'hF0, "mid.pre2");
    applyReset("mid.reset");
    checkVal("mid.empty", 32'(evtEmpty), 32'd1);
    idleCycle("mid.idle");
    sendByte(8'h1C, "mid.code");
    checkVal("mid.head", 32'(evtData), 32'h01C);
    drain("t6");

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 9) != 0);
      r = int'($urandom_range(0, 7));
      rb = 8'($urandom);
      if (r == 0) rb = 8'hE0;
      else if (r == 1) rb = 8'hF0;
      else if (r == 2) rb = 8'hE1;
      applyStimulus(($urandom_range(0, 9) < 6), rb, ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), "rand");
    end
    en = 1'b1;
    drain("rand");

    // Error counter saturation
    for (int i = 0; i < ERR_MAX + 5; i++)
      applyStimulus(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, "sat");
    checkVal("sat.errcnt", 32'(errCount), 32'(ERR_MAX));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_sequencer.md
Name: ps2_scancode_sequencer

Overview:
Sits between the PS/2 keyboard byte receiver and the CPU bus. It pulls bytes from the receiver with a req/ack handshake and parses scan-code set 2 prefixes (E0 extended, F0 break, E1 pause sequence). Completed key events are pushed into a small first-word-fall-through event FIFO that software pops. Parity-errored bytes resynchronise the parser and are counted.

Parameters:
DEPTH, 8, event FIFO depth in entries; power of two, at least 2.
ERR_W, 8, width of the saturating parity-error counter.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
en  input  1  enables byte requests; when low, no new bytes are requested and parser state is held
kbd_req  output  1  byte request to the receiver
kbd_data  input  8  received byte, valid when kbd_ack=1
kbd_err  input  1  parity error flag for kbd_data, valid when kbd_ack=1
kbd_ack  input  1  one-cycle pulse: byte delivered
evt_rd  input  1  pop head event; ignored when evt_empty=1
evt_data  output  10  head event: [9]=released, [8]=extended, [7:0]=code
evt_empty  output  1  FIFO empty
evt_count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky: an event was dropped because the FIFO was full
ovf_clr  input  1  clears overflow; set wins if both occur in the same cycle
err_count  output  ERR_W  saturating count of bytes received with kbd_err=1

Behaviour:
- Reset (rst=0, asynchronous): parser in IDLE, FIFO empty, evt_empty=1, evt_count=0, evt_data=0, overflow=0, err_count=0, kbd_req=0.
- kbd_req is registered. It is 1 when en=1 and evt_count<DEPTH, and updates one cycle after either condition changes.
- A kbd_ack is consumed only when it arrives; kbd_ack while kbd_req=0 is still consumed. No byte is ever lost silently.
- Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (skipping bytes).
- IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip counter=7; any other byte b -> push {0,0,b}, stay IDLE.
- EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte b -> push {0,1,b}, go IDLE.
- BRK: any byte b -> push {1,0,b}, go IDLE.
- EXT_BRK: any byte b -> push {1,1,b}, go IDLE.
- PAUSE: decrement the skip counter on each byte; when it reaches 0, push {0,1,8'h77} and go IDLE. This covers the E1 14 77 E1 F0 14 F0 77 sequence.
- kbd_err=1 with kbd_ack: the byte is discarded, the FSM goes to IDLE, the skip counter clears, and err_count increments, saturating at all-ones.
- Latency: kbd_ack at edge N causes the push to be visible at edge N+1, with evt_empty=0 and evt_data valid.
- Push when full and evt_rd=0: event dropped, overflow set to 1, FSM still returns to IDLE.
- Push when full with evt_rd=1 in the same cycle: both happen; count stays at DEPTH.
- Push and pop when not full: both happen; count unchanged.
- Pop when empty: no effect; pointers do not move.
- Pointers wrap modulo DEPTH; an extra count bit distinguishes full from empty.
- en=0 mid-sequence: FSM state is retained, and a pending ack is still processed.

Decomposition:
- Package ps2_kbd_pkg holds:
  - codes SC_EXT=8'hE0, SC_BRK=8'hF0, SC_PAUSE=8'hE1, PAUSE_SKIP=7, PAUSE_CODE=8'h77;
  - the FSM state encoding;
  - the event bit indices (EVT_REL=9, EVT_EXT=8).
- Sub-module ps2_event_fifo: synchronous FWFT FIFO of width 10 and depth DEPTH, with push/pop/full/empty/count and the same reset. The parent module holds the FSM, request logic, overflow and error counter.

Test Plan:
- Bytes 1C; then F0,1C -> events 0x01C then 0x21C; evt_empty falls the cycle after the first ack.
- Bytes E0,75; then E0,F0,75 -> events 0x175 then 0x375.
- Pause sequence E1,14,77,E1,F0,14,F0,77 -> exactly one event 0x177; no other events.
- F0 delivered with kbd_err=1, then 1C -> err_count=1, single event 0x01C (make, not break).
- 9 make codes with DEPTH=8 and no reads -> kbd_req drops after the 8th; a forced 9th ack sets overflow=1 and count stays 8. ovf_clr then clears overflow; 8 pops return the codes in order and evt_empty=1.
- Assert rst low mid E0,F0 sequence, release, then send 1C -> FIFO empty after reset, then event 0x01C.
